fetch_pc_unit: RTL

//  Program-counter and instruction-fetch stage for the pipelined ARM core.
//  It consumes the branch redirect produced at the end of execute (noop flag

---
 rtl/fetch_pc_unit.sv | 100 ++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch stage: drives the imem req/ack handshake,
// applies execute-stage redirects and feeds decode, inserting NOP bubbles after a branch.
module fetch_pc_unit #(
    parameter int                 ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
    parameter int                 PC_INC       = 4,
    parameter int                 FLUSH_CYCLES = 2,
    parameter logic [31:0]        NOP_WORD     = 32'hE1A0_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              flushing
);

    typedef enum logic {FETCH, FLUSH} state_t;

    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(PC_INC);
    localparam logic [3:0]        FLUSH_LEN = 4'(FLUSH_CYCLES);

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, ipc_n;
    logic [3:0]        flush_cnt, cnt_n;
    logic [31:0]       instr_n;
    logic              vld_n;

    // Targets are word aligned; the low bits are dropped on redirect.
    logic unused_target_bits;
    assign unused_target_bits = ^branch_target[1:0];

    assign imem_addr = pc;
    assign imem_req  = (state == FETCH) && !stall && !reset;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        cnt_n   = flush_cnt;
        instr_n = instr;
        ipc_n   = instr_pc;
        vld_n   = instr_valid;
        if (branch_taken) begin
            // Redirect wins even under stall; a same-cycle ack is dropped.
            pc_n    = {branch_target[ADDR_W-1:2], 2'b00};
            instr_n = NOP_WORD;
            vld_n   = 1'b0;
            if (FLUSH_CYCLES > 0) begin
                state_n = FLUSH;
                cnt_n   = FLUSH_LEN;
            end
        end else if (!stall) begin
            if (state == FETCH) begin
                if (imem_ack && imem_req) begin
                    instr_n = imem_rdata;
                    ipc_n   = pc;
                    vld_n   = 1'b1;
                    pc_n    = pc + PC_STEP;
                end else begin
                    instr_n = NOP_WORD;
                    vld_n   = 1'b0;
                end
            end else begin
                instr_n = NOP_WORD;
                vld_n   = 1'b0;
                cnt_n   = flush_cnt - 4'd1;
                if (flush_cnt <= 4'd1)
                    state_n = FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            flush_cnt   <= '0;
            instr       <= NOP_WORD;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            flushing    <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            flush_cnt   <= cnt_n;
            instr       <= instr_n;
            instr_pc    <= ipc_n;
            instr_valid <= vld_n;
            flushing    <= (state_n == FLUSH);
        end
    end

endmodule
